mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified program/data memory between the core's instruction-fetch port (IF)
//  and load/store port (LS). Round-robin arbitration, one access issued per cycle, fixed-latency
//  synchronous memory. Responses are routed back to the issuing port in order.
//  Sits between core fetch/LSU and the memory macro.
// PARAMETERS
//  ADDR_W   12   word address width (memory depth = 1<<ADDR_W words)
//  DATA_W   32   data width
//  MEM_LAT  1    memory read latency in cycles (>=1); depth of response tag pipeline
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        reset, asynchronous, active-high
//  if_req_valid   in   1        IF read request
//  if_req_ready   out  1        IF request accepted this cycle
//  if_req_addr    in   ADDR_W   IF word address
//  if_rsp_valid   out  1        IF read data valid
//  if_rsp_rdata   out  DATA_W   IF read data
//  ls_req_valid   in   1        LS request
//  ls_req_ready   out  1        LS request accepted this cycle
//  ls_req_we      in   1        1 = store (SW), 0 = load (LW)
//  ls_req_addr    in   ADDR_W   LS word address
//  ls_req_wdata   in   DATA_W   store data
//  ls_rsp_valid   out  1        LS response (load data or store ack)
//  ls_rsp_rdata   out  DATA_W   load data; 0 for store ack
//  mem_en         out  1        memory access enable
//  mem_we         out  1        memory write enable
//  mem_addr       out  ADDR_W   memory address
//  mem_wdata      out  DATA_W   memory write data
//  mem_rdata      in   DATA_W   memory read data, valid MEM_LAT cycles after mem_en edge
// BEHAVIOUR
//  - Reset: all outputs 0; tag pipeline cleared; last_grant = IF (LS wins first contest).
//  - Grant (combinational): only one valid -> grant it; both valid -> grant port != last_grant;
//    none -> no grant. *_req_ready = grant for that port. Accept = valid && ready.
//  - last_grant updates to accepted port at each accept edge; unchanged when idle.
//  - On accept, mem_en=1, mem_we=(LS ? ls_req_we : 0), mem_addr/mem_wdata from granted port,
//    driven combinationally in the accept cycle; memory samples at that edge.
//    mem_wdata = 0 when not a store.
//  - Tag pipeline: MEM_LAT stages of {valid, port, we}, shifted every cycle.
//    Stage MEM_LAT-1 valid -> exactly one of *_rsp_valid pulses 1 cycle,
//    MEM_LAT cycles after the accept edge.
//  - rsp_rdata = mem_rdata for a read response, else 0. Store ack on ls_rsp_valid, rdata = 0.
//  - Throughput: 1 accept/cycle sustained. Alternating grants under continuous dual requests.
//    Responses strictly in issue order; no backpressure on response side.
//  - Requester protocol: valid/addr/we/wdata held stable until accepted; valid not withdrawn.
//  - Simultaneous: accept and response in same cycle are independent (pipelined).
//  - Reset mid-operation: in-flight tags dropped, no response emitted for them.
//  - Address arithmetic: none; addresses pass through unmodified, no wrap or range check.
// STRUCTURE
//  - Package rvme_mem_pkg: port_id_e {PORT_IF, PORT_LS}; struct mem_tag_t {valid, port, we};
//    ADDR_W/DATA_W defaults.
//  - Sub-module rr_arb2: 2-way round-robin grant with last_grant register. Top holds the mux,
//    tag pipeline, and response demux.
// TESTING
//  - Reset then IF only: addr 0x010 valid -> if_req_ready=1 same cycle, mem_addr=0x010;
//    MEM_LAT later if_rsp_valid=1, rdata = MEM[0x010].
//  - Both valid after reset, IF 0x001, LS load 0x002 -> LS granted first, IF next cycle;
//    rsp order LS then IF.
//  - Continuous dual requests 8 cycles -> grants alternate LS,IF,... 4 each;
//    ready never high on both ports.
//  - LS store 0x020 <- 0xDEADBEEF, then LS load 0x020 -> mem_we=1 once; ack rdata=0;
//    load returns 0xDEADBEEF.
//  - MEM_LAT=3, back-to-back IF 0x0..0x3 -> 4 responses on consecutive cycles starting 3 after first accept.
//  - Assert rst with 2 requests in flight -> no *_rsp_valid afterwards; outputs 0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: port identifiers,
// response tag layout and default bus widths.
package rvme_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  // One entry per access in flight through the memory read latency.
  typedef struct packed {
    logic     valid;
    port_id_e port;
    logic     we;
  } mem_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory macro signals.
// slave  : arbiter view (takes requests, drives the memory)
// master : environment view (requesters and memory macro)
interface mem_port_arbiter_if
  import rvme_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_rdata;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant between fetch and load/store.
// Grants are combinational; the port that won last is remembered so a
// simultaneous request goes to the other one. Reset makes LS win first.
module rr_arb2
  import rvme_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if,
  output logic gnt_ls
);

  port_id_e last_grant;

  // Grant selection; held off entirely while reset is asserted.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (!rst) begin
      if (req_if && req_ls) begin
        if (last_grant == PORT_IF) gnt_ls = 1'b1;
        else                       gnt_if = 1'b1;
      end else begin
        gnt_if = req_if;
        gnt_ls = req_ls;
      end
    end
  end

  // A grant is always an accept, so track the winner on every grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= PORT_IF;
    else if (gnt_ls) last_grant <= PORT_LS;
    else if (gnt_if) last_grant <= PORT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between instruction fetch and load/store.
// One access issued per cycle; a tag pipeline as deep as the memory latency
// steers each returning word back to the port that issued it, in order.
module mem_port_arbiter
  import rvme_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  logic              gnt_if;
  logic              gnt_ls;
  logic              issue;
  logic              issue_we;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [DATA_W-1:0] rsp_data;
  mem_tag_t          tag_q [MEM_LAT];
  mem_tag_t          tag_tail;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_if (bus.if_req_valid),
    .req_ls (bus.ls_req_valid),
    .gnt_if (gnt_if),
    .gnt_ls (gnt_ls)
  );

  // Request mux: the granted port drives the memory in its accept cycle.
  always_comb begin
    issue     = gnt_if | gnt_ls;
    issue_we  = gnt_ls & bus.ls_req_we;
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt_ls)      addr_mux = bus.ls_req_addr;
    else if (gnt_if) addr_mux = bus.if_req_addr;
    if (issue_we)    wdata_mux = bus.ls_req_wdata;

    bus.if_req_ready = gnt_if;
    bus.ls_req_ready = gnt_ls;
    bus.mem_en       = issue;
    bus.mem_we       = issue_we;
    bus.mem_addr     = addr_mux;
    bus.mem_wdata    = wdata_mux;
  end

  // Tag pipeline: shifts every cycle so the tail lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue, port: (gnt_ls ? PORT_LS : PORT_IF), we: issue_we};
      for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Response demux: store acks return zero data, idle ports return zero.
  always_comb begin
    tag_tail          = tag_q[MEM_LAT-1];
    rsp_data          = (tag_tail.valid && !tag_tail.we) ? bus.mem_rdata : '0;
    bus.if_rsp_valid  = tag_tail.valid && (tag_tail.port == PORT_IF);
    bus.ls_rsp_valid  = tag_tail.valid && (tag_tail.port == PORT_LS);
    bus.if_rsp_rdata  = bus.if_rsp_valid ? rsp_data : '0;
    bus.ls_rsp_rdata  = bus.ls_rsp_valid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (memory latency 1 and 3) share
// one directed stimulus stream; a per-instance reference model checks every
// cycle, and logged traffic is compared against hand-computed literals.
module tb_mem_port_arbiter;

  typedef struct {
    int          due;
    bit          ls;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          ls;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [11:0] if_addr = '0;
  logic        ls_valid = 1'b0;
  logic        ls_we = 1'b0;
  logic [11:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [11:0] ifq[$];
  req_t        lsq[$];

  bit   grant_log[$];
  rsp_t rsp_log0[$];
  int   acc_cyc1[$];
  int   rsp_cyc1[$];
  int   we_cnt0  = 0;
  int   both_rdy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.if_req_valid = if_valid;
    assign bus.if_req_addr  = if_addr;
    assign bus.ls_req_valid = ls_valid;
    assign bus.ls_req_we    = ls_we;
    assign bus.ls_req_addr  = ls_addr;
    assign bus.ls_req_wdata = ls_wdata;

    // Memory macro: synchronous, LAT-cycle read data, garbage when idle.
    logic [31:0] mem [4096];
    logic [31:0] pipe [3];
    initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end
    always @(posedge clk) begin
      if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        pipe[0] <= mem[bus.mem_addr];
      end else begin
        pipe[0] <= 32'hBAD0_BAD0;
      end
      pipe[1] <= pipe[1-1];
      pipe[2] <= pipe[2-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // Reference model: round-robin from the rules, golden memory, and a
    // queue of responses each due LAT cycles after its accept.
    initial begin : model
      pend_t       pend[$];
      pend_t       p;
      logic [31:0] gold [4096];
      bit          last_ls;
      bit          any, g_ls, e_we;
      bit          e_ifr, e_lsr, e_ifv, e_lsv;
      logic [31:0] e_addr, e_wdata, e_ifd, e_lsd;
      string       tg;
      for (int a = 0; a < 4096; a++) gold[a] = 32'hC0DE_0000 | 32'(a);
      last_ls = 1'b0;
      tg = $sformatf("L%0d", LAT);
      forever begin
        @(negedge clk);
        any = 0; g_ls = 0; e_we = 0; e_ifr = 0; e_lsr = 0;
        e_ifv = 0; e_lsv = 0; e_addr = '0; e_wdata = '0; e_ifd = '0; e_lsd = '0;
        if (!rst) begin
          any  = if_valid || ls_valid;
          g_ls = (if_valid && ls_valid) ? !last_ls : ls_valid;
          e_ifr = any && !g_ls;
          e_lsr = any && g_ls;
          e_we  = g_ls && ls_we;
          e_addr  = 32'(g_ls ? ls_addr : if_addr);
          e_wdata = e_we ? ls_wdata : '0;
          if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (p.ls) begin e_lsv = 1; e_lsd = p.data; end
            else      begin e_ifv = 1; e_ifd = p.data; end
          end
        end
        check({tg, " if_req_ready"}, 32'(bus.if_req_ready), 32'(e_ifr));
        check({tg, " ls_req_ready"}, 32'(bus.ls_req_ready), 32'(e_lsr));
        check({tg, " mem_en"},       32'(bus.mem_en),       32'(any));
        check({tg, " mem_we"},       32'(bus.mem_we),       32'(e_we));
        if (any || rst) begin
          check({tg, " mem_addr"},  32'(bus.mem_addr), e_addr);
          check({tg, " mem_wdata"}, bus.mem_wdata,     e_wdata);
        end
        check({tg, " if_rsp_valid"}, 32'(bus.if_rsp_valid), 32'(e_ifv));
        check({tg, " if_rsp_rdata"}, bus.if_rsp_rdata,      e_ifd);
        check({tg, " ls_rsp_valid"}, 32'(bus.ls_rsp_valid), 32'(e_lsv));
        check({tg, " ls_rsp_rdata"}, bus.ls_rsp_rdata,      e_lsd);

        if (rst) begin
          pend.delete();
          last_ls = 1'b0;
        end else if (any) begin
          last_ls = g_ls;
          p.due  = cyc + LAT;
          p.ls   = g_ls;
          p.data = e_we ? 32'h0 : gold[e_addr[11:0]];
          if (e_we) gold[e_addr[11:0]] = e_wdata;
          pend.push_back(p);
        end

        if (LAT == 1) begin
          if (bus.mem_en) grant_log.push_back(bus.ls_req_ready);
          if (bus.if_req_ready && bus.ls_req_ready) both_rdy++;
          if (bus.mem_we) we_cnt0++;
          if (bus.if_rsp_valid) rsp_log0.push_back('{ls: 1'b0, data: bus.if_rsp_rdata});
          if (bus.ls_rsp_valid) rsp_log0.push_back('{ls: 1'b1, data: bus.ls_rsp_rdata});
        end else begin
          if (bus.mem_en) acc_cyc1.push_back(cyc);
          if (bus.if_rsp_valid || bus.ls_rsp_valid) rsp_cyc1.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    rsp_log0.delete();
    acc_cyc1.delete();
    rsp_cyc1.delete();
    we_cnt0  = 0;
    both_rdy = 0;
  endtask

  // One cycle of the requester protocol: present queue heads, pop on accept.
  task automatic step();
    bit a_if, a_ls;
    if_valid = ifq.size() > 0;
    if (if_valid) if_addr = ifq[0];
    ls_valid = lsq.size() > 0;
    ls_we    = 1'b0;
    if (ls_valid) begin
      ls_we    = lsq[0].we;
      ls_addr  = lsq[0].addr;
      ls_wdata = lsq[0].wdata;
    end
    @(negedge clk);
    a_if = g_inst[0].bus.if_req_ready;
    a_ls = g_inst[0].bus.ls_req_ready;
    @(posedge clk);
    #1;
    if (a_if && ifq.size() > 0) void'(ifq.pop_front());
    if (a_ls && lsq.size() > 0) void'(lsq.pop_front());
  endtask

  task automatic drain(input int max_cyc, output int n);
    n = 0;
    while ((ifq.size() > 0 || lsq.size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_done", 32'(ifq.size() + lsq.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int   n;
    logic [7:0] gvec;
    int   ls_cnt;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // IF alone: accepted the cycle it is presented, data from 0x010.
    clear_logs();
    ifq.push_back(12'h010);
    drain(10, n);
    idle(4);
    check("t1_accept_cycles", 32'(n), 32'd1);
    check("t1_grant_count", 32'(grant_log.size()), 32'd1);
    check("t1_rsp_count", 32'(rsp_log0.size()), 32'd1);
    check("t1_rsp_port", 32'(rsp_log0[0].ls), 32'd0);
    check("t1_rsp_data", rsp_log0[0].data, 32'hC0DE_0010);

    // Both valid after reset: LS wins first, responses LS then IF.
    do_reset();
    clear_logs();
    ifq.push_back(12'h001);
    lsq.push_back('{we: 1'b0, addr: 12'h002, wdata: 32'h0});
    drain(10, n);
    idle(4);
    check("t2_grant_order", {30'd0, grant_log[0], grant_log[1]}, 32'b10);
    check("t2_rsp_count", 32'(rsp_log0.size()), 32'd2);
    check("t2_rsp0", {31'd0, rsp_log0[0].ls} ^ rsp_log0[0].data, 32'hC0DE_0003);
    check("t2_rsp1", {31'd0, rsp_log0[1].ls} ^ rsp_log0[1].data, 32'hC0DE_0001);

    // Continuous dual requests: strict alternation, never both ready.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      ifq.push_back(12'h100 + 12'(i));
      lsq.push_back('{we: 1'b0, addr: 12'h200 + 12'(i), wdata: 32'h0});
    end
    drain(20, n);
    idle(4);
    gvec = '0;
    ls_cnt = 0;
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      gvec[7-i] = grant_log[i];
      if (grant_log[i]) ls_cnt++;
    end
    check("t3_cycles", 32'(n), 32'd8);
    check("t3_grant_pattern", 32'(gvec), 32'h0000_00AA);
    check("t3_ls_grants", 32'(ls_cnt), 32'd4);
    check("t3_both_ready", 32'(both_rdy), 32'd0);

    // Store then load at 0x020.
    clear_logs();
    lsq.push_back('{we: 1'b1, addr: 12'h020, wdata: 32'hDEAD_BEEF});
    lsq.push_back('{we: 1'b0, addr: 12'h020, wdata: 32'h0});
    drain(10, n);
    idle(4);
    check("t4_we_pulses", 32'(we_cnt0), 32'd1);
    check("t4_rsp_count", 32'(rsp_log0.size()), 32'd2);
    check("t4_ack_data", rsp_log0[0].data, 32'h0);
    check("t4_ack_port", 32'(rsp_log0[0].ls), 32'd1);
    check("t4_load_data", rsp_log0[1].data, 32'hDEAD_BEEF);

    // Latency 3, back-to-back fetches 0x0..0x3.
    clear_logs();
    for (int i = 0; i < 4; i++) ifq.push_back(12'(i));
    drain(10, n);
    idle(5);
    check("t5_accepts", 32'(acc_cyc1.size()), 32'd4);
    check("t5_rsps", 32'(rsp_cyc1.size()), 32'd4);
    check("t5_first_lat", 32'(rsp_cyc1[0] - acc_cyc1[0]), 32'd3);
    check("t5_consecutive", 32'(rsp_cyc1[3] - rsp_cyc1[0]), 32'd3);

    // Reset with requests in flight: immediate zeros, in-flight dropped.
    ifq.push_back(12'h040);
    ifq.push_back(12'h041);
    step();
    step();
    rst      = 1'b1;
    if_valid = 1'b1;
    ls_valid = 1'b1;
    clear_logs();
    @(negedge clk);
    check("t6_l1_outputs", {27'd0, g_inst[0].bus.if_req_ready, g_inst[0].bus.ls_req_ready,
          g_inst[0].bus.mem_en, g_inst[0].bus.if_rsp_valid, g_inst[0].bus.ls_rsp_valid}, 32'd0);
    check("t6_l3_outputs", {27'd0, g_inst[1].bus.if_req_ready, g_inst[1].bus.ls_req_ready,
          g_inst[1].bus.mem_en, g_inst[1].bus.if_rsp_valid, g_inst[1].bus.ls_rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    check("t6_l1_no_rsp", 32'(rsp_log0.size()), 32'd0);
    check("t6_l3_no_rsp", 32'(rsp_cyc1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
